conv_window_loader: RTL and testbench

- Upstream feeder for the Convolution stage: gathers a serial stream of 64-bit IEEE-754 double samples into a frame of N entries, then presents the frame as a packed x1 vector with its length (len1).
- Ping-pong double buffering: one bank is presented to Convolution while the other fills, so the input stream keeps running during convolution.
- Frame handoff to the consumer uses a valid/ack handshake.

---
 rtl/conv_window_loader.sv | 103 ++++++++++
 tb/tb_conv_window_loader.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_loader.sv
// Ping-pong frame gatherer feeding the convolution stage: one bank fills from the
// sample stream while the other is presented as a zero-padded x1 vector.
module conv_window_loader #(
    parameter int N  = 16,
    parameter int W  = 64,
    parameter int LW = $clog2(N + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [W-1:0]          in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [0:N-1][0:W-1]   x1,
    output logic [LW-1:0]         x1_len,
    output logic                  x1_valid,
    input  logic                  x1_ack
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic [IW-1:0] wr_idx_q, wr_idx_d;
    logic [1:0]    full_q, full_d;
    logic [LW-1:0] len_q [2];
    logic [LW-1:0] len_d [2];
    logic [W-1:0]  bank_mem [2][N];

    logic accept;
    logic seal;
    logic rel_frame;

    // Write and release always target different banks: the written bank is never
    // full, the released one always is, so both updates can be applied together.
    always_comb begin
        in_ready  = reset && !full_q[wr_bank_q];
        accept    = in_valid && in_ready;
        seal      = accept && ((wr_idx_q == LAST_IDX) || in_last);
        rel_frame = x1_ack && full_q[rd_bank_q];

        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_idx_d  = wr_idx_q;
        full_d    = full_q;
        len_d[0]  = len_q[0];
        len_d[1]  = len_q[1];

        if (accept) begin
            if (seal) begin
                full_d[wr_bank_q] = 1'b1;
                len_d[wr_bank_q]  = LW'(wr_idx_q) + LW'(1);
                wr_idx_d          = '0;
                wr_bank_d         = !wr_bank_q;
            end else begin
                wr_idx_d = wr_idx_q + IW'(1);
            end
        end

        if (rel_frame) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = !rd_bank_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_idx_q  <= '0;
            full_q    <= '0;
            len_q[0]  <= '0;
            len_q[1]  <= '0;
        end else begin
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_idx_q  <= wr_idx_d;
            full_q    <= full_d;
            len_q[0]  <= len_d[0];
            len_q[1]  <= len_d[1];
        end
    end

    // Sample storage carries no reset; validity is tracked entirely by full_q/len_q.
    always_ff @(posedge clk) begin
        if (accept) begin
            bank_mem[wr_bank_q][wr_idx_q] <= in_data;
        end
    end

    always_comb begin
        x1_valid = full_q[rd_bank_q];
        x1_len   = x1_valid ? len_q[rd_bank_q] : '0;
        for (int i = 0; i < N; i++) begin
            x1[i] = '0;
            if (x1_valid && (LW'(i) < len_q[rd_bank_q])) begin
                x1[i] = bank_mem[rd_bank_q][i];
            end
        end
    end

endmodule

// File: tb/tb_conv_window_loader.sv
// Bench for conv_window_loader: directed scenarios plus randomized traffic, with a
// frame-level reference model feeding a scoreboard queue checked by a monitor.
module tb_conv_window_loader;

    localparam int N  = 16;
    localparam int W  = 64;
    localparam int LW = $clog2(N + 1);

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic [W-1:0]        in_data = '0;
    logic                in_valid = 1'b0;
    logic                in_last = 1'b0;
    logic                in_ready;
    logic [0:N-1][0:W-1] x1;
    logic [LW-1:0]       x1_len;
    logic                x1_valid;
    logic                x1_ack = 1'b0;

    typedef struct {
        logic [W-1:0] d [N];
        int           len;
    } frame_t;

    frame_t       exp_q [$];
    frame_t       blank;
    logic [W-1:0] cur_d [N];
    int           cur_len = 0;
    int           errors = 0;
    int           checks = 0;
    bit           rand_done = 1'b0;

    conv_window_loader #(.N(N), .W(W), .LW(LW)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .x1       (x1),
        .x1_len   (x1_len),
        .x1_valid (x1_valid),
        .x1_ack   (x1_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] rb(input int k);
        return $realtobits(real'(k) / 10.0);
    endfunction

    task automatic check_bit(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic check_word(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Compares the whole presented vector against the expected frame (or all-zero).
    task automatic check_output(input bit showing, input frame_t f);
        int           bad;
        logic [W-1:0] e;
        logic [W-1:0] a;
        bad = -1;
        check_word("x1_len", W'(x1_len), showing ? W'(f.len) : '0);
        for (int i = 0; i < N; i++) begin
            e = showing ? f.d[i] : '0;
            a = x1[i];
            if ((a !== e) && (bad < 0)) bad = i;
        end
        checks++;
        if (bad >= 0) begin
            errors++;
            e = showing ? f.d[bad] : '0;
            a = x1[bad];
            $display("[TB] FAIL x1_entry[%0d]: got %h expected %h at %0t", bad, a, e, $time);
        end
    endtask

    // Reference model: samples accumulate into a frame that closes at N entries or in_last.
    task automatic model_accept(input logic [W-1:0] d, input bit last);
        frame_t f;
        cur_d[cur_len] = d;
        cur_len++;
        if (last || (cur_len == N)) begin
            for (int i = 0; i < N; i++) f.d[i] = (i < cur_len) ? cur_d[i] : '0;
            f.len = cur_len;
            exp_q.push_back(f);
            cur_len = 0;
        end
    endtask

    task automatic apply_stimulus(input logic [W-1:0] d, input bit last);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && (waited < 200)) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got in_ready=0 expected 1 within 200 cycles at %0t", $time);
            in_valid = 1'b0;
            in_last  = 1'b0;
            return;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        model_accept(d, last);
    endtask

    task automatic send_frame(input int k0, input int n, input bit short_last);
        for (int j = 0; j < n; j++) begin
            apply_stimulus(rb(k0 + j), short_last && (j == n - 1));
        end
    endtask

    task automatic pulse_ack();
        x1_ack = 1'b1;
        @(negedge clk);
        x1_ack = 1'b0;
    endtask

    // Monitor: pops the next expected frame whenever a new frame should be on display.
    initial begin
        frame_t cur;
        bit     showing;
        bit     pending;
        bit     exp_valid;
        showing = 1'b0;
        pending = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!reset) begin
                check_bit("rst_x1_valid", x1_valid, 1'b0);
                check_bit("rst_in_ready", in_ready, 1'b0);
                check_output(1'b0, blank);
                showing = 1'b0;
                pending = 1'b0;
            end else begin
                if (pending && showing) showing = 1'b0;
                exp_valid = showing || (exp_q.size() > 0);
                check_bit("x1_valid", x1_valid, exp_valid);
                if (exp_valid && !showing) begin
                    cur     = exp_q.pop_front();
                    showing = 1'b1;
                end
                check_output(showing, cur);
                check_bit("in_ready", in_ready, (exp_q.size() + int'(showing)) < 2);
                pending = x1_ack && showing;
            end
        end
    end

    initial begin
        blank.len = 0;
        for (int i = 0; i < N; i++) blank.d[i] = '0;

        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        $display("[TB] full frame, no ack");
        send_frame(1, 16, 1'b0);
        #1;
        check_bit("t1_valid", x1_valid, 1'b1);
        check_word("t1_len", W'(x1_len), W'(16));
        check_word("t1_x1_0", x1[0], rb(1));
        check_word("t1_x1_15", x1[15], rb(16));
        check_bit("t1_in_ready", in_ready, 1'b1);

        $display("[TB] second bank fills, producer stalls");
        @(negedge clk);
        send_frame(21, 16, 1'b0);
        #1;
        check_bit("t2_in_ready_low", in_ready, 1'b0);
        @(negedge clk);
        fork
            apply_stimulus(rb(5), 1'b0);
            begin
                repeat (3) @(negedge clk);
                pulse_ack();
            end
        join
        #1;
        check_bit("t2_valid_held", x1_valid, 1'b1);
        check_word("t2_x1_0", x1[0], rb(21));
        check_word("t2_x1_15", x1[15], rb(36));

        $display("[TB] short frame");
        @(negedge clk);
        send_frame(6, 3, 1'b0);
        pulse_ack();
        apply_stimulus(rb(9), 1'b1);
        #1;
        check_word("t3_len", W'(x1_len), W'(5));
        check_word("t3_x1_0", x1[0], rb(5));
        check_word("t3_x1_4", x1[4], rb(9));
        check_word("t3_x1_5", x1[5], '0);

        $display("[TB] stray ack while idle");
        @(negedge clk);
        pulse_ack();
        pulse_ack();
        #1;
        check_bit("t4_idle", x1_valid, 1'b0);
        @(negedge clk);
        send_frame(41, 16, 1'b0);
        #1;
        check_word("t4_x1_0", x1[0], rb(41));

        $display("[TB] reset mid-fill");
        @(negedge clk);
        pulse_ack();
        send_frame(61, 16, 1'b0);
        send_frame(71, 7, 1'b0);
        #2;
        reset = 1'b0;
        exp_q.delete();
        cur_len = 0;
        #1;
        check_bit("t5_valid", x1_valid, 1'b0);
        check_bit("t5_in_ready", in_ready, 1'b0);
        check_output(1'b0, blank);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        send_frame(101, 16, 1'b0);
        #1;
        check_word("t5_x1_0", x1[0], rb(101));

        $display("[TB] seal and ack in the same cycle");
        @(negedge clk);
        send_frame(121, 2, 1'b0);
        fork
            apply_stimulus(rb(123), 1'b1);
            pulse_ack();
        join
        #1;
        check_bit("t6_valid", x1_valid, 1'b1);
        check_word("t6_len", W'(x1_len), W'(3));
        check_word("t6_x1_2", x1[2], rb(123));
        check_word("t6_x1_3", x1[3], '0);
        check_bit("t6_in_ready", in_ready, 1'b1);
        @(negedge clk);
        send_frame(131, 16, 1'b0);
        pulse_ack();

        $display("[TB] randomized traffic");
        fork
            begin
                int flen;
                int idle;
                bit last;
                for (int f = 0; f < 30; f++) begin
                    flen = $urandom_range(1, 16);
                    for (int j = 0; j < flen; j++) begin
                        idle = $urandom_range(0, 2);
                        repeat (idle) begin
                            in_valid = 1'b0;
                            in_last  = ($urandom_range(0, 1) == 1);
                            in_data  = {$urandom, $urandom};
                            @(negedge clk);
                        end
                        in_last = 1'b0;
                        last = (j == flen - 1) && ((flen < 16) || ($urandom_range(0, 1) == 1));
                        apply_stimulus({$urandom, $urandom}, last);
                    end
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    x1_ack = ($urandom_range(0, 2) == 0);
                    @(negedge clk);
                end
                x1_ack = 1'b0;
            end
        join

        x1_ack = 1'b1;
        repeat (6) @(negedge clk);
        x1_ack = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_bit("end_idle", x1_valid, 1'b0);
        check_bit("end_in_ready", in_ready, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
